extream_pool: RTL
=================

EXTREAM_POOL -- requirements
Module: extream_pool

Interface
REQ-001 The module SHALL have parameter level, default 4, with N = 1<<(level-1) slots.
REQ-002 The module SHALL have parameter data_sz, default 4, as the width of each entry in bits.
REQ-003 The module SHALL have parameter comparator, default 0; 0 selects a min pool and 1 selects a max pool, matching the downstream extreme-value tree.
REQ-004 Port clk, input, 1 bit: the single clock; all state SHALL update on the rising edge.
REQ-005 Port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 Port in_valid, input, 1 bit: insert request.
REQ-007 Port in_data, input, data_sz bits: the value to insert.
REQ-008 Port in_ready, output, 1 bit: the pool can accept an insert.
REQ-009 Port pop_req, input, 1 bit: request to remove the current extreme entry.
REQ-010 Port pop_ack, output, 1 bit: registered pulse for one cycle; the pop completed.
REQ-011 Port pop_err, output, 1 bit: registered pulse for one cycle; the pop was rejected.
REQ-012 Port pop_data, output, data_sz bits: registered value of the removed entry.
REQ-013 Port flush, input, 1 bit: invalidate all slots.
REQ-014 Port raw, output, N*data_sz bits: packed slot vector to the tree, with slot i at bits [i*data_sz +: data_sz].
REQ-015 Port tree_result, input, data_sz bits: the extreme value returned combinationally by the tree.
REQ-016 Port count, output, level bits: number of valid slots, from 0 to N.
REQ-017 Port empty, output, 1 bit: high when count == 0.
REQ-018 Port full, output, 1 bit: high when count == N.

Function
REQ-019 Each slot SHALL hold a data register and a valid bit.
REQ-020 raw SHALL carry the slot data for valid slots.
REQ-021 For invalid slots, raw SHALL carry the neutral value: all-ones when comparator=0, all-zeros when comparator=1.
REQ-022 in_ready SHALL equal !full, computed from registered state only and never from pop_req in the same cycle.
REQ-023 An insert SHALL be accepted when in_valid && in_ready && !flush.
REQ-024 An accepted insert SHALL write in_data into the lowest-index free slot, chosen from pre-edge valid bits, and set that slot's valid bit at the edge.
REQ-025 A pop SHALL be attempted when pop_req && !flush.
REQ-026 On an attempted pop, the block SHALL select the lowest-index valid slot whose data == tree_result, using the same-cycle combinational result.
REQ-027 On a successful pop, the selected slot's valid bit SHALL clear at the edge, and in the next cycle pop_ack=1 and pop_data=tree_result.
REQ-028 On a pop attempted while empty, or when no valid slot matches, no state SHALL change, and in the next cycle pop_err=1, pop_ack=0, and pop_data SHALL hold its previous value.
REQ-029 On a simultaneous accepted insert and successful pop, both SHALL take effect and count SHALL be unchanged.
REQ-030 The inserted slot SHALL be a pre-edge free slot, so it never collides with the popped slot.
REQ-031 When the pool is full with insert and pop both requested, the insert SHALL be refused (in_ready=0), only the pop SHALL complete, and count SHALL become N-1.
REQ-032 count SHALL go +1 on an insert only, -1 on a pop only, and stay unchanged on both or neither; it SHALL never wrap.
REQ-033 flush SHALL clear all valid bits and set count=0 at the edge.
REQ-034 flush SHALL take priority: an insert or pop in the same cycle is dropped, with no pop_ack and no pop_err in the next cycle.
REQ-035 Slot data registers SHALL NOT be cleared by flush or by a pop; only the valid bits change.
REQ-036 Duplicate values SHALL be allowed, and each pop SHALL remove exactly one instance.

Reset
REQ-037 When rst_n=0 at a clock edge, all valid bits, count, pop_ack, pop_err and pop_data SHALL be cleared to 0.
REQ-038 After that reset edge, empty=1, full=0, in_ready=1, and raw SHALL be all-neutral.
REQ-039 Reset SHALL override flush, insert and pop in the same cycle.
REQ-040 A pop pending at reset SHALL produce no pop_ack or pop_err pulse afterwards.
REQ-041 Slot data registers SHALL need no reset.

Verification
REQ-042 Min pool, level=4, data_sz=4: insert 5,3,9,3, then pop twice -> pop_data 3 then 3, pops clearing slots 1 then 3, count 4->3->2, raw slots 1 and 3 showing 4'hF.
REQ-043 Fill 8 inserts -> full=1, in_ready=0; a 9th in_valid is ignored; then insert+pop in the same cycle -> only the pop completes, count=7.
REQ-044 count=3, simultaneous insert of 1 and pop of the current minimum 2 -> pop_ack with pop_data=2, 1 written to the lowest free slot, count stays 3.
REQ-045 Pop when empty -> pop_err pulse one cycle later, count=0, pop_ack=0.
REQ-046 flush with in_valid and pop_req high at count=5 -> count=0, raw all 4'hF, no ack or err; then rst_n low mid-stream -> all outputs per REQ-037.
REQ-047 comparator=1 pool: insert 2,7,7 and pop -> pop_data=7 taken from slot 1, slot 2 still valid, empty slots showing 4'h0.

Source files
------------

// File: rtl/extream_pool.sv
// Slot pool feeding an external extreme-value tree: inserts fill the lowest free
// slot, pops remove the lowest-index slot whose data equals the tree's result.
module extream_pool #(
  parameter int level      = 4,
  parameter int data_sz    = 4,
  parameter int comparator = 0
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  input  logic [data_sz-1:0]                  in_data,
  output logic                                in_ready,
  input  logic                                pop_req,
  output logic                                pop_ack,
  output logic                                pop_err,
  output logic [data_sz-1:0]                  pop_data,
  input  logic                                flush,
  output logic [(1<<(level-1))*data_sz-1:0]   raw,
  input  logic [data_sz-1:0]                  tree_result,
  output logic [level-1:0]                    count,
  output logic                                empty,
  output logic                                full
);

  localparam int N  = 1 << (level-1);
  localparam int IW = (level > 1) ? level-1 : 1;
  localparam logic [data_sz-1:0] NEUTRAL = (comparator != 0) ? '0 : '1;
  localparam logic [level-1:0]   NCNT    = level'(N);

  logic [data_sz-1:0] data_q [N];
  logic [N-1:0]       valid_q, valid_d;
  logic [level-1:0]   count_q, count_d;
  logic               pop_ack_q, pop_err_q;
  logic [data_sz-1:0] pop_data_q;

  logic [IW-1:0] ins_idx, pop_idx;
  logic          pop_hit, ins_acc, pop_try, pop_ok;

  assign full     = (count_q == NCNT);
  assign empty    = (count_q == '0);
  assign in_ready = !full;
  assign count    = count_q;
  assign pop_ack  = pop_ack_q;
  assign pop_err  = pop_err_q;
  assign pop_data = pop_data_q;

  assign ins_acc = in_valid && in_ready && !flush;
  assign pop_try = pop_req && !flush;
  assign pop_ok  = pop_try && pop_hit;

  // Descending scans so the last hit written is the lowest index.
  always_comb begin
    ins_idx = '0;
    pop_idx = '0;
    pop_hit = 1'b0;
    for (int i = N-1; i >= 0; i--) begin
      if (!valid_q[i]) ins_idx = IW'(i);
      if (valid_q[i] && (data_q[i] == tree_result)) begin
        pop_idx = IW'(i);
        pop_hit = 1'b1;
      end
    end
  end

  // Insert picks a pre-edge free slot, so it can never alias the popped slot.
  always_comb begin
    valid_d = valid_q;
    count_d = count_q;
    if (ins_acc) valid_d[ins_idx] = 1'b1;
    if (pop_ok)  valid_d[pop_idx] = 1'b0;
    case ({ins_acc, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (flush) begin
      valid_d = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q    <= '0;
      count_q    <= '0;
      pop_ack_q  <= 1'b0;
      pop_err_q  <= 1'b0;
      pop_data_q <= '0;
    end else begin
      valid_q   <= valid_d;
      count_q   <= count_d;
      pop_ack_q <= pop_ok;
      pop_err_q <= pop_try && !pop_hit;
      if (pop_ok) pop_data_q <= tree_result;
    end
  end

  // Data storage is never cleared; validity alone decides what the tree sees.
  always_ff @(posedge clk) begin
    if (rst_n && ins_acc) data_q[ins_idx] <= in_data;
  end

  for (genvar g = 0; g < N; g++) begin : g_raw
    assign raw[g*data_sz +: data_sz] = valid_q[g] ? data_q[g] : NEUTRAL;
  end

endmodule
